encoder8x3_arbiter: RTL and testbench



---
 rtl/encoder8x3_arbiter.sv | 123 ++++++++++++
 tb/tb_encoder8x3_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/encoder8x3_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : encoder8x3_arbiter
// Description : Collects 8 request lines into a pending register and grants the
//               highest-priority eligible index over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder8x3_arbiter #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       out_ready,
    input  logic       ovf_clr,
    output logic       out_valid,
    output logic [2:0] out_code,
    output logic [7:0] pending,
    output logic [7:0] overflow
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t     state_q,    state_d;
    logic       valid_q,    valid_d;
    logic [2:0] code_q,     code_d;
    logic [7:0] pending_q,  pending_d;
    logic [7:0] overflow_q, overflow_d;

    logic [7:0] w_eligible;
    logic [7:0] w_eligible2;
    logic [7:0] w_code_onehot;
    logic [7:0] w_clr;
    logic [2:0] w_sel;
    logic [2:0] w_sel2;
    logic       w_fire;

    function automatic logic [2:0] prio_sel(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        // Later matches overwrite earlier ones, so the last index visited wins.
        for (int i = 0; i < 8; i++) begin
            if (HIGH_FIRST) begin
                if (v[i]) idx = 3'(i);
            end else begin
                if (v[7-i]) idx = 3'(7 - i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        w_fire        = valid_q & out_ready;
        w_code_onehot = 8'd1 << code_q;
        w_clr         = w_fire ? w_code_onehot : 8'd0;
        w_eligible    = (pending_q | req) & ~mask;
        w_eligible2   = w_eligible & ~w_code_onehot;
        w_sel         = prio_sel(w_eligible);
        w_sel2        = prio_sel(w_eligible2);
    end

    // A request arriving on the same edge its index is retired re-arms the bit.
    always_comb begin
        pending_d  = (pending_q & ~w_clr) | req;
        overflow_d = (overflow_q & ~{8{ovf_clr}}) | (req & pending_q & ~w_clr);
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (|w_eligible) begin
                    code_d  = w_sel;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_fire) begin
                    if (|w_eligible2) begin
                        code_d = w_sel2;
                    end else begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            code_q     <= 3'd0;
            pending_q  <= 8'd0;
            overflow_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = valid_q;
    assign out_code  = code_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder8x3_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder8x3_arbiter
// Description : Randomized and directed bench for both priority orders.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder8x3_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [7:0] mask;
    logic       out_ready;
    logic       ovf_clr;

    // Index 0: HIGH_FIRST=0 (bit 0 highest), index 1: HIGH_FIRST=1 (bit 7 highest)
    logic       d_valid [2];
    logic [2:0] d_code  [2];
    logic [7:0] d_pend  [2];
    logic [7:0] d_ovf   [2];

    logic       m_valid [2];
    logic [2:0] m_code  [2];
    logic [7:0] m_pend  [2];
    logic [7:0] m_ovf   [2];

    int  n_vec = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    encoder8x3_arbiter #(.HIGH_FIRST(1'b0)) u_lo (
        .clk(clk), .reset(reset), .req(req), .mask(mask),
        .out_ready(out_ready), .ovf_clr(ovf_clr),
        .out_valid(d_valid[0]), .out_code(d_code[0]),
        .pending(d_pend[0]), .overflow(d_ovf[0])
    );

    encoder8x3_arbiter #(.HIGH_FIRST(1'b1)) u_hi (
        .clk(clk), .reset(reset), .req(req), .mask(mask),
        .out_ready(out_ready), .ovf_clr(ovf_clr),
        .out_valid(d_valid[1]), .out_code(d_code[1]),
        .pending(d_pend[1]), .overflow(d_ovf[1])
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Highest-priority set bit of v; -1 when v is empty.
    function automatic int pick(input logic [7:0] v, input int hf);
        for (int k = 0; k < 8; k++) begin
            int b;
            b = (hf != 0) ? 7 - k : k;
            if (v[b]) return b;
        end
        return -1;
    endfunction

    task automatic tick();
        logic       nv [2];
        logic [2:0] nc [2];
        logic [7:0] np [2];
        logic [7:0] no [2];
        for (int h = 0; h < 2; h++) begin
            logic [7:0] elig, clr, rest;
            bit fire;
            elig  = (m_pend[h] | req) & ~mask;
            fire  = m_valid[h] && out_ready;
            clr   = fire ? (8'd1 << m_code[h]) : 8'd0;
            np[h] = (m_pend[h] & ~clr) | req;
            no[h] = (ovf_clr ? 8'd0 : m_ovf[h]) | (req & m_pend[h] & ~clr);
            nv[h] = m_valid[h];
            nc[h] = m_code[h];
            if (!m_valid[h]) begin
                if (elig != 0) begin
                    nv[h] = 1'b1;
                    nc[h] = 3'(pick(elig, h));
                end
            end else if (fire) begin
                rest = elig & ~(8'd1 << m_code[h]);
                if (rest != 0) nc[h] = 3'(pick(rest, h));
                else           nv[h] = 1'b0;
            end
            if (reset) begin
                nv[h] = 1'b0; nc[h] = 3'd0; np[h] = 8'd0; no[h] = 8'd0;
            end
        end
        @(posedge clk);
        #1;
        for (int h = 0; h < 2; h++) begin
            m_valid[h] = nv[h]; m_code[h] = nc[h]; m_pend[h] = np[h]; m_ovf[h] = no[h];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 8'd0; mask = 8'd0; out_ready = 1'b0; ovf_clr = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int h = 0; h < 2; h++) begin
                chk($sformatf("valid[%0d]", h), 8'(d_valid[h]), 8'(m_valid[h]));
                chk($sformatf("pending[%0d]", h), d_pend[h], m_pend[h]);
                chk($sformatf("overflow[%0d]", h), d_ovf[h], m_ovf[h]);
                if (m_valid[h]) chk($sformatf("code[%0d]", h), 8'(d_code[h]), 8'(m_code[h]));
            end
        end
    end

    initial begin
        for (int h = 0; h < 2; h++) begin
            m_valid[h] = 1'b0; m_code[h] = 3'd0; m_pend[h] = 8'd0; m_ovf[h] = 8'd0;
        end
        do_reset();
        for (int h = 0; h < 2; h++) begin
            chk("rst_valid", 8'(d_valid[h]), 8'd0);
            chk("rst_code", 8'(d_code[h]), 8'd0);
            chk("rst_pending", d_pend[h], 8'd0);
            chk("rst_overflow", d_ovf[h], 8'd0);
        end
        chk_en = 1'b1;

        // Single request, immediate acceptance
        do_reset();
        req = 8'h10; out_ready = 1'b1;
        tick();
        req = 8'h00;
        chk("t1_valid", 8'(d_valid[1]), 8'd1);
        chk("t1_code", 8'(d_code[1]), 8'd4);
        chk("t1_model_code", 8'(m_code[1]), 8'd4);
        tick();
        chk("t1_pending", d_pend[1], 8'h00);
        chk("t1_valid_off", 8'(d_valid[1]), 8'd0);

        // Two requests granted back-to-back in each priority order
        do_reset();
        req = 8'h81; out_ready = 1'b1;
        tick();
        req = 8'h00;
        chk("t2_hi_first", 8'(d_code[1]), 8'd7);
        chk("t2_lo_first", 8'(d_code[0]), 8'd0);
        tick();
        chk("t2_hi_second", 8'(d_code[1]), 8'd0);
        chk("t2_lo_second", 8'(d_code[0]), 8'd7);
        chk("t2_hi_valid2", 8'(d_valid[1]), 8'd1);
        tick();
        chk("t2_hi_done", 8'(d_valid[1]), 8'd0);
        chk("t2_lo_done", 8'(d_valid[0]), 8'd0);

        // Held code is stable under back-pressure
        do_reset();
        req = 8'h04;
        repeat (5) tick();
        req = 8'h80;
        tick();
        req = 8'h00;
        chk("t3_hold_hi", 8'(d_code[1]), 8'd2);
        chk("t3_hold_lo", 8'(d_code[0]), 8'd2);
        chk("t3_ovf", d_ovf[1], 8'h04);
        out_ready = 1'b1;
        tick();
        chk("t3_next_hi", 8'(d_code[1]), 8'd7);
        chk("t3_next_lo", 8'(d_code[0]), 8'd7);
        tick();

        // Masked request accumulates but is not granted until unmasked
        do_reset();
        mask = 8'h04; req = 8'h04; out_ready = 1'b1;
        tick();
        req = 8'h00;
        tick();
        chk("t4_masked_valid", 8'(d_valid[1]), 8'd0);
        chk("t4_masked_pend", d_pend[1], 8'h04);
        mask = 8'h00;
        tick();
        chk("t4_unmask_code", 8'(d_code[1]), 8'd2);
        chk("t4_unmask_valid", 8'(d_valid[1]), 8'd1);
        tick();

        // Overflow set and cleared
        do_reset();
        req = 8'h08;
        tick();
        tick();
        req = 8'h00;
        chk("t5_ovf_set", d_ovf[1], 8'h08);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t5_ovf_clr", d_ovf[1], 8'h00);

        // Reset wins over a handshake in flight
        do_reset();
        req = 8'h20;
        tick();
        req = 8'h00;
        chk("t6_hold", 8'(d_code[1]), 8'd5);
        reset = 1'b1; out_ready = 1'b1;
        tick();
        reset = 1'b0; out_ready = 1'b0;
        chk("t6_valid", 8'(d_valid[1]), 8'd0);
        chk("t6_pending", d_pend[1], 8'h00);
        chk("t6_code", 8'(d_code[1]), 8'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            req       = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(($urandom & $urandom) & 8'hFF);
            mask      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 40) == 0) mask = 8'hFF;
            out_ready = ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; req = 8'h00;
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
